// File: rtl/arith_serial_if.sv
// arith_serial_if: valid/ready request and response bundle for arith_serial
interface arith_serial_if #(parameter int WIDTH = 8);
  logic in_valid, in_ready, SUB, out_valid, out_ready, OV;
  logic [WIDTH-1:0] A, B, SUM;
  modport master (output in_valid, A, B, SUB, out_ready, input in_ready, out_valid, SUM, OV);
  modport slave (input in_valid, A, B, SUB, out_ready, output in_ready, out_valid, SUM, OV);
endinterface

// File: rtl/arith_serial.sv
// arith_serial: bit-serial two's-complement adder/subtractor, LSB first, valid/ready handshakes
module arith_serial #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  arith_serial_if.slave s
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic carry_q, carry_d, ov_q, ov_d, sum_bit, carry_out, last, accept;
  assign last = cnt_q == CW'(WIDTH - 1);
  assign accept = state_q == IDLE && s.in_valid;
  // state register
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  // datapath registers: operand shifters, result shifter, carry, bit counter, held result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      r_q <= '0;
      sum_q <= '0;
      cnt_q <= '0;
      carry_q <= 1'b0;
      ov_q <= 1'b0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      r_q <= r_d;
      sum_q <= sum_d;
      cnt_q <= cnt_d;
      carry_q <= carry_d;
      ov_q <= ov_d;
    end
  end
  // next state: accept in IDLE, finish after the MSB, release on response handshake
  always_comb
    state_d = accept ? CALC :
              (state_q == CALC && last) ? DONE :
              (state_q == DONE && s.out_ready) ? IDLE : state_q;
  // one full-adder step per CALC cycle; subtraction is A + ~B with carry-in 1
  always_comb begin
    sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    carry_out = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    a_d = a_q;
    b_d = b_q;
    r_d = r_q;
    cnt_d = cnt_q;
    carry_d = carry_q;
    sum_d = sum_q;
    ov_d = ov_q;
    if (accept) begin
      a_d = s.A;
      b_d = s.B ^ {WIDTH{s.SUB}};
      r_d = '0;
      cnt_d = '0;
      carry_d = s.SUB;
    end else if (state_q == CALC) begin
      a_d = a_q >> 1;
      b_d = b_q >> 1;
      r_d = {sum_bit, r_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
      carry_d = carry_out;
      sum_d = last ? r_d : sum_q;
      ov_d = last ? carry_q ^ carry_out : ov_q;
    end
  end
  // handshake flags decode the state register only
  always_comb begin
    s.in_ready = state_q == IDLE;
    s.out_valid = state_q == DONE;
    s.SUM = sum_q;
    s.OV = ov_q;
  end
endmodule

// File: tb/tb_arith_serial.sv
// tb_arith_serial: scoreboard bench for arith_serial with directed vectors and a random sweep
module tb_arith_serial;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  arith_serial_if #(.WIDTH(W)) ifc ();
  arith_serial #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .s(ifc));
  int checks = 0, errs = 0, cyc = 0, sent = 0, got = 0;
  logic [W:0] exp_q[$];
  int acc_q[$];
  logic rdy_dir = 1'b1, rand_rdy = 1'b0, prev_ov = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W:0] ref_f(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    logic [W-1:0] r;
    logic ov;
    r = sub ? a - b : a + b;
    ov = sub ? (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]) : (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
    return {ov, r};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send(logic [W-1:0] a, logic [W-1:0] b, logic sub);
    int n = 0;
    @(negedge clk);
    ifc.A = a;
    ifc.B = b;
    ifc.SUB = sub;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.in_ready) begin
      check("accept_timeout", 32'(ifc.in_ready), 32'd1);
      ifc.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(ref_f(a, b, sub));
    sent++;
    @(posedge clk);
    #1;
    acc_q.push_back(cyc);
    ifc.in_valid = 1'b0;
  endtask

  task automatic wait_ov();
    int n = 0;
    while (!ifc.out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_timeout", 32'(ifc.out_valid), 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    ifc.in_valid = 1'b0;
    ifc.A = '0;
    ifc.B = '0;
    ifc.SUB = 1'b0;
    ifc.out_ready = 1'b1;
    fork
      forever begin
        @(negedge clk);
        if (rst) prev_ov = 1'b0;
        else begin
          if (ifc.out_valid && !prev_ov) begin
            if (acc_q.size() == 0) check("latency_unexpected", 32'd1, 32'd0);
            else check("latency", 32'(cyc - acc_q.pop_front()), 32'(W));
          end
          if (ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) check("duplicate_result", 32'd1, 32'd0);
            else begin
              logic [W:0] e;
              e = exp_q.pop_front();
              check("sum", 32'(ifc.SUM), 32'(e[W-1:0]));
              check("ov", 32'(ifc.OV), 32'(e[W]));
              got++;
            end
          end
          prev_ov = ifc.out_valid;
        end
      end
      forever begin
        @(posedge clk);
        #1;
        ifc.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_dir;
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(ifc.in_ready), 32'd1);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_sum", 32'(ifc.SUM), 32'h00);
        check("rst_ov", 32'(ifc.OV), 32'd0);
        send(8'hFF, 8'hF0, 1'b0);
        send(8'hFE, 8'hF1, 1'b0);
        send(8'h7F, 8'h01, 1'b0);
        send(8'h80, 8'h01, 1'b1);
        send(8'h05, 8'h05, 1'b1);
        drain();
        check("dir_ff_f0", 32'(ref_f(8'hFF, 8'hF0, 1'b0)), 32'h0EF);
        rdy_dir = 1'b0;
        send(8'h7F, 8'h01, 1'b0);
        wait_ov();
        repeat (20) begin
          @(negedge clk);
          check("bp_sum", 32'(ifc.SUM), 32'h80);
          check("bp_ov", 32'(ifc.OV), 32'd1);
          check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
          check("bp_out_valid", 32'(ifc.out_valid), 32'd1);
        end
        rdy_dir = 1'b1;
        drain();
        rdy_dir = 1'b0;
        send(8'h10, 8'h20, 1'b1);
        repeat (14) begin
          @(negedge clk);
          ifc.A = W'($urandom);
          ifc.B = W'($urandom);
          ifc.SUB = 1'($urandom);
          ifc.in_valid = 1'($urandom_range(0, 1));
        end
        ifc.in_valid = 1'b0;
        check("toggle_held", 32'(ifc.out_valid), 32'd1);
        rdy_dir = 1'b1;
        drain();
        send(8'h7F, 8'h01, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        acc_q.delete();
        sent--;
        @(negedge clk);
        check("abort_in_ready", 32'(ifc.in_ready), 32'd1);
        check("abort_out_valid", 32'(ifc.out_valid), 32'd0);
        check("abort_sum", 32'(ifc.SUM), 32'h00);
        check("abort_ov", 32'(ifc.OV), 32'd0);
        send(8'h01, 8'h02, 1'b0);
        drain();
        rand_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send(W'($urandom), W'($urandom), 1'($urandom));
        end
        drain();
        rand_rdy = 1'b0;
        check("no_drop", 32'(got), 32'(sent));
        check("latency_queue_empty", 32'(acc_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errs);
        $finish;
      end
    join
  end
endmodule

// File: doc/arith_serial.md
# arith_serial

Bit-serial 8-bit two's-complement adder/subtractor with valid/ready request and response handshakes. It is the responder counterpart to the operand-driving stimulus side of the `arith` interface. It accepts one `{A, B, SUB}` request, computes the result LSB-first over `WIDTH` cycles, and holds `SUM`/`OV` until the consumer takes them. Its results are bit-identical to the combinational `arith` block, so it can replace that block on area-constrained paths.

## Interface
- `WIDTH`, default 8: operand and result width in bits; must be ≥ 2.
- `clk` input 1: system clock; all state changes on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: request present on `A`, `B`, `SUB`.
- `in_ready` output 1: block can accept a request.
- `A` input `WIDTH`: first operand, two's complement.
- `B` input `WIDTH`: second operand, two's complement.
- `SUB` input 1: 0 computes A+B; 1 computes A−B.
- `out_valid` output 1: `SUM`/`OV` hold a valid result.
- `out_ready` input 1: consumer takes the result.
- `SUM` output `WIDTH`: result, modulo 2^WIDTH.
- `OV` output 1: signed overflow of the operation.

## Operation
- States: IDLE, CALC, DONE. The state is encoded in registers.
- IDLE
  - `in_ready` = 1; `out_valid` = 0.
  - Acceptance occurs when `in_valid` && `in_ready` && !`rst` at a rising edge.
  - On acceptance, capture `A` into the operand shifter and `B ^ {WIDTH{SUB}}` into the second shifter.
  - Set carry = `SUB`, bit counter = 0, clear the result shifter, then go to CALC.
- CALC
  - `in_ready` = 0; `out_valid` = 0.
  - Each edge computes sum bit = a0 ^ b0 ^ carry and carry = majority(a0, b0, carry).
  - Shift the operands right by one; shift the sum bit into the result MSB, so the result is LSB-first and right-aligned after `WIDTH` shifts.
  - On the edge that processes bit `WIDTH-1`:
    - OV = carry-into-MSB ^ carry-out-of-MSB.
    - Load `SUM` from the completed result and go to DONE.
- DONE
  - `out_valid` = 1; `in_ready` = 0.
  - `SUM`/`OV` stay stable until `out_valid` && `out_ready` at an edge; the state then goes to IDLE.
- `A`, `B`, `SUB`, and `in_valid` are ignored outside the acceptance edge. Changing them during CALC or DONE has no effect.
- `out_ready` is ignored outside DONE.
- `SUM`/`OV` keep their last values in IDLE and CALC. They change only on the edge that enters DONE, or on reset.
- Arithmetic is identical to WIDTH-bit two's-complement A+B or A+~B+1. The carry-out is not exported.

## Timing
- Reset values after any edge with `rst` = 1:
  - state = IDLE, `in_ready` = 1, `out_valid` = 0, `SUM` = 0, `OV` = 0.
  - Counter, carry, and shifters = 0.
- Reset has priority over every other event, including acceptance or completion on the same edge.
- Reset mid-CALC or mid-DONE aborts the operation and no result is emitted.
- No request is accepted on an edge where `rst` = 1.
- Latency: if acceptance is on edge E0, `out_valid` rises after edge E`WIDTH` (E8 for WIDTH = 8), i.e. `WIDTH` cycles after acceptance.
- Response handshake on edge Ek; IDLE (`in_ready` = 1) from the next cycle. There is no same-edge re-accept.
- Minimum request spacing is `WIDTH`+2 cycles (10 for WIDTH = 8).
- Back-pressure: with `out_ready` held low, DONE persists indefinitely with outputs stable.
- `in_ready` and `out_valid` are pure decodes of the state register. They have no combinational path from `in_valid` or `out_ready`.

## Test plan
- Reset, then check: `in_ready` = 1, `out_valid` = 0, `SUM` = 00, `OV` = 0.
- Accept A=FF, B=F0, SUB=0 with `out_ready` = 1 → `out_valid` exactly 8 cycles after acceptance, `SUM` = EF, `OV` = 0. Follow with A=FE, B=F1, SUB=0 → `SUM` = EF, `OV` = 0.
- Overflow cases:
  - A=7F, B=01, SUB=0 → `SUM` = 80, `OV` = 1.
  - A=80, B=01, SUB=1 → `SUM` = 7F, `OV` = 1.
  - A=05, B=05, SUB=1 → `SUM` = 00, `OV` = 0.
- Back-pressure:
  - Hold `out_ready` = 0 for 20 cycles after `out_valid` → `SUM`/`OV` stable and `in_ready` = 0 throughout.
  - Toggle `A`/`B`/`in_valid` during CALC and DONE → result unchanged.
- Assert `rst` for one cycle at CALC bit 4 of A=7F, B=01 → next cycle IDLE, `out_valid` = 0, `SUM` = 00. A new request A=01, B=02, SUB=0 then yields `SUM` = 03.
- Random sweep of 1000 {A, B, SUB} requests with random `in_valid`/`out_ready` gaps → every result matches the combinational `arith` reference model, and no request is dropped or duplicated.
